uart_tx8: RTL and testbench
===========================

Name: uart_tx8

Overview:
- Parameterized UART transmitter; serial-side counterpart of the team's 8x-oversampling receiver.
- Shares the same bd8_rate enable, so one bit period is 8 bd8_rate pulses.
- Accepts a byte over a valid/ready handshake on the system clock.
- Serializes the byte LSB-first with optional parity and 1 or 2 stop bits.
- Sits between the host-side byte source and the tx pad.

Parameters:
- PARITY, "ODD": "ODD" sends odd parity, "EVEN" sends even parity, any other string sends no parity bit.
- STOP_BIT, 1: number of stop bits. 1 or 2; any other value behaves as 1.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bd8_rate  in  1  one-clk-wide enable pulse at 8x the baud rate.
- tx_data  in  8  byte to send; sampled on acceptance.
- tx_valid  in  1  byte request from the source.
- tx_ready  out  1  high when a new byte can be accepted.
- tx  out  1  serial line; idles high.
- tx_done  out  1  one-clk pulse when the last stop bit completes.

Behaviour:
- Reset: one clock; the reset is synchronous and active-high. With rst high at a clk edge:
  - tx=1, tx_ready=1, tx_done=0.
  - State IDLE; tick and bit counters cleared; pending flag cleared.
  - Reset mid-frame aborts the frame; tx returns high on that edge.
- Acceptance:
  - Occurs on a clk edge where tx_valid and tx_ready are both high.
  - tx_data is latched into a shift register; a pending flag is set.
  - tx_ready drops from the next cycle.
  - tx_valid while tx_ready=0 is ignored; the byte is not queued.
- Timing: all serial state advances only on clk edges where bd8_rate=1.
- States:
  - IDLE: tx=1. On the first bd8_rate pulse with pending set, go to START, drive tx=0 and clear the tick counter. Data accepted on the same edge as a bd8_rate pulse waits for the next pulse.
  - START: hold tx=0 for 8 pulses. On the 8th pulse go to DATA, drive bit 0.
  - DATA: each bit is held for 8 pulses; 3-bit bit counter. After bit 7's 8th pulse:
    - go to PAR if parity is enabled, driving the parity bit;
    - otherwise go to STOP1, driving 1.
  - PAR: parity bit is ~^data for ODD and ^data for EVEN, computed from the latched byte. Hold 8 pulses, then STOP1.
  - STOP1: tx=1 for 8 pulses. Then STOP2 if STOP_BIT==2, else IDLE.
  - STOP2: tx=1 for 8 pulses, then IDLE.
- Frame end:
  - On the edge that leaves the final stop state: tx_done=1 for exactly one clk and tx_ready=1 again.
  - A byte presented then is accepted and starts at the next bd8_rate pulse, so back-to-back frames have no extra idle.
- Frame length: 8*(1+8+P+S) bd8_rate pulses, where P is 0 or 1 and S is STOP_BIT.
- Output register: tx comes from a flop; there are no combinational paths from inputs to tx.
- Glitches: tx never glitches between bits, since it changes only on bd8_rate edges.
- Boundary conditions:
  - bd8_rate held high continuously: one tick per clk.
  - bd8_rate never pulsing: the frame stalls with tx holding its current value.
  - Tick counter wraps 7->0 at every bit boundary.

Test Plan:
- PARITY="ODD", STOP_BIT=1, bd8_rate every 4 clk, send 0x55:
  - tx sequence 0,1,0,1,0,1,0,1,0,P=1,1, each bit exactly 8 pulses (32 clk);
  - tx_done one pulse 88 pulses after start;
  - tx_ready low throughout the frame.
- PARITY="EVEN", STOP_BIT=2, send 0xA7:
  - bits 0,1,1,1,0,0,1,0,1, P=1, then 16 pulses of high;
  - 96 pulses total.
- PARITY="NONE", bd8_rate tied high, send 0x00:
  - tx low for 72 clk, then high for 8;
  - tx_done pulses at clk 80.
- Back-to-back: tx_valid held high with 0x3C then 0xC3:
  - second start bit begins on the first bd8_rate after the first frame's tx_done;
  - a third tx_valid asserted mid-frame is not accepted until tx_ready=1.
- Reset mid-frame: assert rst during DATA bit 4:
  - the next edge gives tx=1, tx_ready=1, tx_done=0;
  - a following 0x81 is sent as a clean full frame.
- Loopback into the team's 8x receiver with matching PARITY/STOP_BIT, bytes 0x00, 0xFF, 0x5A, 0xA5:
  - rx_data matches each byte;
  - no parity error is reported.

Source files
------------

// File: rtl/uart_tx8.sv
// rtl/uart_tx8.sv - 8x-oversampled UART transmitter, LSB first, optional parity, 1 or 2 stop bits
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bd8_rate  one-clk enable at 8x the baud rate; serial state only advances on it
//   tx_data   byte to send, latched on acceptance
//   tx_valid  byte request from the source
//   tx_ready  high when a byte can be accepted
//   tx        registered serial line, idles high
//   tx_done   one-clk pulse as the last stop bit completes
module uart_tx8 #(
  parameter string PARITY   = "ODD",
  parameter int    STOP_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bd8_rate,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_done
);

  localparam bit PAR_EN   = (PARITY == "ODD") || (PARITY == "EVEN");
  localparam bit PAR_ODD  = (PARITY == "ODD");
  localparam bit TWO_STOP = (STOP_BIT == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP1,
    S_STOP2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       pending_q, pending_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;

  logic accept;
  logic tick_last;
  logic parity_bit;

  // Ready only when idle with nothing waiting, so a byte can never be
  // overwritten while it is pending or being shifted out.
  assign tx_ready   = (state_q == S_IDLE) && !pending_q;
  assign accept     = tx_valid && tx_ready;
  assign tick_last  = (tick_q == 3'd7);
  assign parity_bit = PAR_ODD ? ~^data_q : ^data_q;

  assign tx      = tx_q;
  assign tx_done = done_q;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    data_d    = data_q;
    pending_d = pending_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    if (accept) begin
      data_d    = tx_data;
      pending_d = 1'b1;
    end

    if (bd8_rate) begin
      // The tick counter wraps 7->0 naturally at every bit boundary.
      if (state_q != S_IDLE) begin
        tick_d = tick_q + 3'd1;
      end
      case (state_q)
        S_IDLE: begin
          // pending_q is the registered flag, so a byte accepted on this
          // same edge waits for the next pulse.
          if (pending_q) begin
            state_d   = S_START;
            tx_d      = 1'b0;
            tick_d    = 3'd0;
            bit_d     = 3'd0;
            pending_d = 1'b0;
          end
        end
        S_START: begin
          if (tick_last) begin
            state_d = S_DATA;
            tx_d    = data_q[0];
          end
        end
        S_DATA: begin
          if (tick_last) begin
            if (bit_q == 3'd7) begin
              if (PAR_EN) begin
                state_d = S_PAR;
                tx_d    = parity_bit;
              end else begin
                state_d = S_STOP1;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d = bit_q + 3'd1;
              tx_d  = data_q[bit_q + 3'd1];
            end
          end
        end
        S_PAR: begin
          if (tick_last) begin
            state_d = S_STOP1;
            tx_d    = 1'b1;
          end
        end
        S_STOP1: begin
          if (tick_last) begin
            if (TWO_STOP) begin
              state_d = S_STOP2;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        S_STOP2: begin
          if (tick_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= 3'd0;
      bit_q     <= 3'd0;
      data_q    <= 8'h00;
      pending_q <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx8.sv
// tb/tb_uart_tx8.sv - scoreboard bench for uart_tx8 in ODD/1, EVEN/2 and NONE/1 configurations
module tb_uart_tx8;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] bits;
    int          nbits;
    int          gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] bd8 = '0;
  logic [2:0] bd8_en = '0;
  logic [2:0] valid = '0;
  logic [7:0] data [3];
  wire  [2:0] ready;
  wire  [2:0] txo;
  wire  [2:0] done;

  // Per-instance configuration: parity 1=odd 2=even 0=none, stop bits, bd8 divider
  int cfg_par  [3] = '{1, 2, 0};
  int cfg_stop [3] = '{1, 2, 1};
  int div      [3] = '{4, 3, 1};
  int bcnt     [3] = '{0, 0, 0};

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];

  int         sel = 0;
  bit         mon_active = 1'b0;
  int         mon_idx = 0;
  int         mon_idle = 0;
  int         mon_gap = 0;
  int         mon_nb = 0;
  logic [11:0] mon_bits = '0;
  logic       mon_first = 1'b1;
  bit         mon_unstable = 1'b0;
  bit         mon_ready_hi = 1'b0;
  bit         mon_perr = 1'b0;
  bit         done_pend = 1'b0;
  int         frames_done = 0;
  exp_t       mon_e;

  always #5 clk = ~clk;

  uart_tx8 #(.PARITY("ODD"), .STOP_BIT(1)) u_odd (
    .clk(clk), .rst(rst), .bd8_rate(bd8[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx(txo[0]), .tx_done(done[0])
  );
  uart_tx8 #(.PARITY("EVEN"), .STOP_BIT(2)) u_even (
    .clk(clk), .rst(rst), .bd8_rate(bd8[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx(txo[1]), .tx_done(done[1])
  );
  uart_tx8 #(.PARITY("NONE"), .STOP_BIT(1)) u_none (
    .clk(clk), .rst(rst), .bd8_rate(bd8[2]), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx(txo[2]), .tx_done(done[2])
  );

  // bd8 pulses change shortly after the rising edge, stable by the falling edge
  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      if (!bd8_en[i]) begin
        bd8[i]  = 1'b0;
        bcnt[i] = 0;
      end else begin
        bd8[i]  = (bcnt[i] == 0);
        bcnt[i] = (bcnt[i] + 1) % div[i];
      end
    end
  end

  function automatic exp_t make_exp(input int s, input logic [7:0] b, input int gap);
    exp_t e;
    int   ones;
    int   k;
    ones   = 0;
    e.b    = b;
    e.bits = '0;
    for (int i = 0; i < 8; i++) begin
      e.bits[1 + i] = b[i];
      ones += int'(b[i]);
    end
    k = 9;
    if (cfg_par[s] != 0) begin
      e.bits[k] = (cfg_par[s] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      k++;
    end
    for (int j = 0; j < cfg_stop[s]; j++) begin
      e.bits[k] = 1'b1;
      k++;
    end
    e.nbits = k;
    e.gap   = gap;
    return e;
  endfunction

  // Receiver: samples tx once per bd8 pulse, mid-bit decode, checks every
  // bit is held for exactly 8 pulses and tx_done follows the final stop pulse.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      mon_idx    = 0;
      mon_idle   = 0;
      done_pend  = 1'b0;
    end else begin
      if (done_pend) begin
        n_cmp++;
        if (done[sel] !== 1'b1) begin
          n_bad++;
          $display("FAIL tx_done_pulse: got %b want 1", done[sel]);
        end
        done_pend = 1'b0;
      end else if (done[sel] === 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_done_spurious: got 1 want 0");
      end
      if (bd8[sel]) begin
        if (!mon_active && txo[sel] === 1'b0) begin
          mon_active   = 1'b1;
          mon_idx      = 0;
          mon_gap      = mon_idle;
          mon_bits     = '0;
          mon_unstable = 1'b0;
          mon_ready_hi = 1'b0;
        end
        if (mon_active) begin
          if (mon_idx % 8 == 0) mon_first = txo[sel];
          else if (txo[sel] !== mon_first) mon_unstable = 1'b1;
          if (mon_idx % 8 == 4) mon_bits[mon_idx / 8] = txo[sel];
          if (ready[sel] !== 1'b0) mon_ready_hi = 1'b1;
          mon_idx++;
          mon_nb = 9 + ((cfg_par[sel] != 0) ? 1 : 0) + cfg_stop[sel];
          if (mon_idx == 8 * mon_nb) begin
            mon_active = 1'b0;
            mon_idle   = 0;
            done_pend  = 1'b1;
            frames_done++;
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_bad++;
              $display("FAIL unexpected_frame: got bits %h want no frame", mon_bits);
            end else begin
              mon_e = exp_q.pop_front();
              if (mon_unstable || mon_bits !== mon_e.bits) begin
                n_bad++;
                $display("FAIL frame_bits: got %h unstable=%0d want %h", mon_bits, mon_unstable, mon_e.bits);
              end
              n_cmp++;
              if (mon_bits[8:1] !== mon_e.b) begin
                n_bad++;
                $display("FAIL rx_data: got %h want %h", mon_bits[8:1], mon_e.b);
              end
              n_cmp++;
              if (mon_ready_hi !== 1'b0) begin
                n_bad++;
                $display("FAIL ready_in_frame: got high want low");
              end
              if (cfg_par[sel] != 0) begin
                mon_perr = (cfg_par[sel] == 1) ? !(^mon_bits[9:1]) : (^mon_bits[9:1]);
                n_cmp++;
                if (mon_perr !== 1'b0) begin
                  n_bad++;
                  $display("FAIL parity_err: got 1 want 0 (byte %h)", mon_e.b);
                end
              end
              if (mon_e.gap >= 0) begin
                n_cmp++;
                if (mon_gap != mon_e.gap) begin
                  n_bad++;
                  $display("FAIL frame_gap: got %0d want %0d pulses", mon_gap, mon_e.gap);
                end
              end
            end
          end
        end else if (txo[sel] === 1'b1) begin
          mon_idle++;
        end
      end
    end
  end

  task automatic send(input int s, input logic [7:0] b, input int gap, output bit ok);
    int cnt;
    exp_q.push_back(make_exp(s, b, gap));
    @(negedge clk);
    data[s]  = b;
    valid[s] = 1'b1;
    cnt = 0;
    while (ready[s] !== 1'b1 && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    valid[s] = 1'b0;
    ok = (cnt < 4000);
  endtask

  task automatic wait_frames(input int target, output bit ok);
    int cnt;
    cnt = 0;
    while (frames_done < target && cnt < 6000) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    ok = (frames_done >= target);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    valid  = '0;
    bd8_en = 3'b111;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (txo[i] !== 1'b1) begin n_bad++; $display("FAIL reset_tx[%0d]: got %b want 1", i, txo[i]); end
      n_cmp++;
      if (ready[i] !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 1", i, ready[i]); end
      n_cmp++;
      if (done[i] !== 1'b0) begin n_bad++; $display("FAIL reset_done[%0d]: got %b want 0", i, done[i]); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_odd_55();
    bit ok;
    int base;
    sel  = 0;
    base = frames_done;
    send(0, 8'h55, -1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL odd55_accept: got timeout want accept"); end
    wait_frames(base + 1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL odd55_frame: got %0d frames want %0d", frames_done, base + 1); end
  endtask

  task automatic test_even_a7();
    bit ok;
    int base;
    sel  = 1;
    base = frames_done;
    send(1, 8'hA7, -1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL evena7_accept: got timeout want accept"); end
    wait_frames(base + 1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL evena7_frame: got %0d frames want %0d", frames_done, base + 1); end
  endtask

  task automatic test_none_00();
    bit ok;
    int base;
    int cnt;
    int lows;
    int highs;
    sel  = 2;
    base = frames_done;
    send(2, 8'h00, -1, ok);
    cnt = 0;
    while (txo[2] !== 1'b0 && cnt < 100) begin @(negedge clk); cnt++; end
    lows = 0;
    while (txo[2] === 1'b0 && lows < 200) begin lows++; @(negedge clk); end
    highs = 0;
    while (done[2] !== 1'b1 && highs < 200) begin highs++; @(negedge clk); end
    n_cmp++;
    if (lows != 72) begin n_bad++; $display("FAIL none00_low_clks: got %0d want 72", lows); end
    n_cmp++;
    if (highs != 8) begin n_bad++; $display("FAIL none00_high_clks: got %0d want 8", highs); end
    wait_frames(base + 1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL none00_frame: got %0d frames want %0d", frames_done, base + 1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    int cnt;
    sel  = 0;
    base = frames_done;
    exp_q.push_back(make_exp(0, 8'h3C, -1));
    @(negedge clk);
    data[0]  = 8'h3C;
    valid[0] = 1'b1;
    cnt = 0;
    while (ready[0] !== 1'b0 && cnt < 100) begin @(negedge clk); cnt++; end
    data[0] = 8'hC3;
    exp_q.push_back(make_exp(0, 8'hC3, 1));
    cnt = 0;
    while (done[0] !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    @(negedge clk);
    n_cmp++;
    if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept: got ready %b want 0", ready[0]); end
    valid[0] = 1'b0;
    // a short request mid-frame must be dropped, not queued
    repeat (50) @(negedge clk);
    data[0]  = 8'h66;
    valid[0] = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_midframe: got %b want 0", ready[0]); end
    valid[0] = 1'b0;
    repeat (90) @(negedge clk);
    // a held request mid-frame is taken exactly when ready returns
    data[0]  = 8'h11;
    valid[0] = 1'b1;
    exp_q.push_back(make_exp(0, 8'h11, 1));
    cnt = 0;
    while (done[0] !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    @(negedge clk);
    n_cmp++;
    if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_third_accept: got ready %b want 0", ready[0]); end
    valid[0] = 1'b0;
    wait_frames(base + 3, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_frames: got %0d frames want %0d", frames_done, base + 3); end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (txo[0] !== 1'b1 || ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_idle_after: got tx=%b ready=%b want tx=1 ready=1", txo[0], ready[0]);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_queue_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    int cnt;
    sel = 0;
    send(0, 8'h5A, -1, ok);
    cnt = 0;
    while (!(mon_active && mon_idx >= 44) && cnt < 2000) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (cnt >= 2000) begin n_bad++; $display("FAIL rstmid_reach_bit4: got timeout want data bit 4"); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (txo[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx: got %b want 1", txo[0]); end
    n_cmp++;
    if (ready[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", ready[0]); end
    n_cmp++;
    if (done[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done[0]); end
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    base = frames_done;
    send(0, 8'h81, -1, ok);
    wait_frames(base + 1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rstmid_clean_frame: got %0d frames want %0d", frames_done, base + 1); end
  endtask

  task automatic test_loopback();
    bit   ok;
    bit   stable;
    int   base;
    logic held;
    sel  = 1;
    base = frames_done;
    send(1, 8'h00, -1, ok);
    send(1, 8'hFF, -1, ok);
    // stall the enable mid-frame: tx must freeze and the frame resume intact
    repeat (60) @(negedge clk);
    bd8_en[1] = 1'b0;
    repeat (2) @(negedge clk);
    held   = txo[1];
    stable = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (txo[1] !== held) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin n_bad++; $display("FAIL stall_hold: got tx change want held %b", held); end
    bd8_en[1] = 1'b1;
    send(1, 8'h5A, -1, ok);
    send(1, 8'hA5, -1, ok);
    wait_frames(base + 4, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL loopback_frames: got %0d frames want %0d", frames_done, base + 4); end
  endtask

  initial begin
    test_reset();
    test_odd_55();
    test_even_a7();
    test_none_00();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
